// File: rtl/homography_pkg.sv
// Shared types and constants for the projective-transform stage.
package homography_pkg;
   localparam int COEF_W = 16;
   localparam int WIDTH  = 9;
   localparam int FRAC   = 8;
   localparam int ROWS   = 3;
   localparam int TERMS  = 3;
   localparam int ACC_W  = COEF_W + WIDTH + 3;

   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, STORE, DONE} state_t;
endpackage

// File: rtl/homography_project_if.sv
// Transaction bus between the corner source and the divider array.
// start_in is a level sampled only while idle; valid_out is a one-cycle pulse and the data are held afterwards.
interface homography_project_if #(
   parameter int NPTS   = 3,
   parameter int WIDTH  = 9,
   parameter int COEF_W = 16
);
   import homography_pkg::state_t;

   logic                            start_in;
   logic [8:0][COEF_W-1:0]          h_in;
   logic [NPTS-1:0][WIDTH-1:0]      x_in;
   logic [NPTS-1:0][WIDTH-1:0]      y_in;
   logic                            busy_out;
   logic                            valid_out;
   logic [2*NPTS-1:0][WIDTH-1:0]    dividend_out;
   logic [NPTS-1:0][WIDTH-1:0]      divisor_out;
   logic                            w_err_out;
   state_t                          state_dbg;

   modport master (
      output start_in, h_in, x_in, y_in,
      input  busy_out, valid_out, dividend_out, divisor_out, w_err_out, state_dbg
   );

   modport slave (
      input  start_in, h_in, x_in, y_in,
      output busy_out, valid_out, dividend_out, divisor_out, w_err_out, state_dbg
   );
endinterface

// File: rtl/homography_project_mac_unit.sv
// Shared signed multiply-accumulate: clear, add coef*operand, add sign-extended coef.
module mac_unit #(
   parameter int COEF_W = 16,
   parameter int WIDTH  = 9,
   parameter int ACC_W  = COEF_W + WIDTH + 3
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     clear,
   input  logic                     accumulate,
   input  logic                     add_const,
   input  logic signed [COEF_W-1:0] coef,
   input  logic        [WIDTH-1:0]  operand,
   output logic signed [ACC_W-1:0]  acc
);
   logic signed [COEF_W+WIDTH:0] prod;
   logic signed [ACC_W-1:0]      base;
   logic signed [ACC_W-1:0]      add_p;
   logic signed [ACC_W-1:0]      add_c;

   // Operand is an unsigned pixel coordinate, so it gets a zero sign bit.
   assign prod = coef * $signed({1'b0, operand});

   always_comb begin
      base  = clear      ? '0 : acc;
      add_p = accumulate ? ACC_W'(prod) : '0;
      add_c = add_const  ? ACC_W'(coef) : '0;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) acc <= '0;
      else         acc <= base + add_p + add_c;
   end
endmodule

// File: rtl/homography_project.sv
// Sequential homography stage: one shared MAC computes X, Y, W per corner,
// clamps them for the divider array and publishes all corners with one valid pulse.
module homography_project #(
   parameter int NPTS   = 3,
   parameter int WIDTH  = 9,
   parameter int COEF_W = 16,
   parameter int FRAC   = 8
) (
   input logic                 clk_in,
   input logic                 rst_in,
   homography_project_if.slave bus
);
   import homography_pkg::*;

   localparam int ACC_W = COEF_W + WIDTH + 3;
   localparam int PW    = (NPTS > 1) ? $clog2(NPTS) : 1;
   localparam logic [WIDTH-1:0] OMAX = '1;

   state_t state, state_next;
   logic [PW-1:0] p;
   logic [1:0]    r, k;
   logic [3:0]    h_idx;
   logic signed [COEF_W-1:0] h_q [9];
   logic [WIDTH-1:0] x_q [NPTS];
   logic [WIDTH-1:0] y_q [NPTS];
   logic [WIDTH-1:0] res_d [2*NPTS];
   logic [WIDTH-1:0] res_w [NPTS];
   logic err_q;
   logic last_term, last_row, last_pt;
   logic mac_clear, mac_acc, mac_const;
   logic signed [COEF_W-1:0] mac_coef;
   logic [WIDTH-1:0] mac_operand;
   logic signed [ACC_W-1:0] acc, sh, lo_lim, hi_lim;
   logic [WIDTH-1:0] clamped;
   logic w_bad;

   assign last_term = (k == 2'(TERMS-1));
   assign last_row  = (r == 2'(ROWS-1));
   assign last_pt   = (p == PW'(NPTS-1));
   assign bus.state_dbg = state;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next    = state;
      bus.busy_out  = 1'b0;
      bus.valid_out = 1'b0;
      case (state)
         IDLE:    if (bus.start_in) state_next = LOAD;
         LOAD:    state_next = MAC;
         MAC:     if (last_term) state_next = STORE;
         STORE:   state_next = (last_row && last_pt) ? DONE : MAC;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      bus.busy_out  = (state == LOAD) || (state == MAC) || (state == STORE);
      bus.valid_out = (state == DONE);
   end

   // Term k of row r uses h[r][k]; the third term is the translation constant.
   always_comb begin
      h_idx       = 4'(r) * 4'd3 + 4'(k);
      mac_coef    = h_q[h_idx];
      mac_operand = (k == 2'd0) ? x_q[p] : y_q[p];
      mac_clear   = (state == LOAD) || ((state == MAC) && (k == 2'd0));
      mac_acc     = (state == MAC) && !last_term;
      mac_const   = (state == MAC) && last_term;
   end

   mac_unit #(.COEF_W(COEF_W), .WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .clear      (mac_clear),
      .accumulate (mac_acc),
      .add_const  (mac_const),
      .coef       (mac_coef),
      .operand    (mac_operand),
      .acc        (acc)
   );

   // W has a floor of 1 so the downstream divider never sees zero.
   always_comb begin
      sh     = acc >>> FRAC;
      hi_lim = ACC_W'(OMAX);
      lo_lim = last_row ? ACC_W'(1) : '0;
      if (sh < lo_lim)      clamped = lo_lim[WIDTH-1:0];
      else if (sh > hi_lim) clamped = OMAX;
      else                  clamped = sh[WIDTH-1:0];
      w_bad = last_row && (sh[ACC_W-1] || (sh == '0));
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         p     <= '0;
         r     <= '0;
         k     <= '0;
         err_q <= 1'b0;
         bus.w_err_out <= 1'b0;
         for (int i = 0; i < 9; i++) h_q[i] <= '0;
         for (int i = 0; i < NPTS; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            res_w[i] <= WIDTH'(1);
            bus.divisor_out[i] <= WIDTH'(1);
         end
         for (int i = 0; i < 2*NPTS; i++) begin
            res_d[i] <= '0;
            bus.dividend_out[i] <= '0;
         end
      end else begin
         case (state)
            LOAD: begin
               for (int i = 0; i < 9; i++) h_q[i] <= bus.h_in[i];
               for (int i = 0; i < NPTS; i++) begin
                  x_q[i] <= bus.x_in[i];
                  y_q[i] <= bus.y_in[i];
               end
               p     <= '0;
               r     <= '0;
               k     <= '0;
               err_q <= 1'b0;
            end
            MAC: k <= last_term ? 2'd0 : k + 2'd1;
            STORE: begin
               if (r == 2'd0)      res_d[{p, 1'b0}] <= clamped;
               else if (r == 2'd1) res_d[{p, 1'b1}] <= clamped;
               else                res_w[p] <= clamped;
               err_q <= err_q | w_bad;
               if (last_row) begin
                  r <= '0;
                  p <= last_pt ? '0 : p + PW'(1);
               end else begin
                  r <= r + 2'd1;
               end
               // The last W bypasses its register so outputs are ready in the valid cycle.
               if (last_row && last_pt) begin
                  for (int i = 0; i < 2*NPTS; i++) bus.dividend_out[i] <= res_d[i];
                  for (int i = 0; i < NPTS; i++)
                     bus.divisor_out[i] <= (i == NPTS-1) ? clamped : res_w[i];
                  bus.w_err_out <= err_q | w_bad;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_homography_project.sv
// Scoreboard bench for homography_project: driver pushes model results, monitor pops on valid_out.
module tb_homography_project;
   localparam int NPTS   = 3;
   localparam int WIDTH  = 9;
   localparam int COEF_W = 16;
   localparam int FRAC   = 8;
   localparam int LAT    = 12*NPTS + 2;
   localparam int EXP_W  = 3*NPTS*WIDTH + 1;

   typedef int h_arr_t [9];
   typedef int pt_arr_t [NPTS];

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   logic [EXP_W-1:0] exp_q [$];
   int               lat_q [$];
   logic [EXP_W-1:0] last_exp;
   logic [EXP_W-1:0] rst_exp;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   homography_project_if #(.NPTS(NPTS), .WIDTH(WIDTH), .COEF_W(COEF_W)) bus ();

   homography_project #(.NPTS(NPTS), .WIDTH(WIDTH), .COEF_W(COEF_W), .FRAC(FRAC)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic longint floor_div(input longint v, input longint d);
      longint q;
      q = v / d;
      if ((v % d != 0) && (v < 0)) q = q - 1;
      return q;
   endfunction

   // Reference: each output is floor((h_r0*x + h_r1*y + h_r2) / 2^FRAC), then clamped.
   function automatic logic [EXP_W-1:0] model(input h_arr_t h, input pt_arr_t xs, input pt_arr_t ys);
      logic [EXP_W-1:0] e;
      longint v, q, lo, hi;
      e  = '0;
      hi = (longint'(1) << WIDTH) - 1;
      for (int p = 0; p < NPTS; p++) begin
         for (int row = 0; row < 3; row++) begin
            v  = longint'(h[3*row]) * xs[p] + longint'(h[3*row+1]) * ys[p] + h[3*row+2];
            q  = floor_div(v, longint'(1) << FRAC);
            lo = (row == 2) ? 1 : 0;
            if (row == 2 && q <= 0) e[EXP_W-1] = 1'b1;
            if (q < lo) q = lo;
            if (q > hi) q = hi;
            if (row < 2) e[(2*p+row)*WIDTH +: WIDTH] = WIDTH'(q);
            else         e[(2*NPTS+p)*WIDTH +: WIDTH] = WIDTH'(q);
         end
      end
      return e;
   endfunction

   function automatic logic [EXP_W-1:0] reset_vec();
      logic [EXP_W-1:0] e;
      e = '0;
      for (int p = 0; p < NPTS; p++) e[(2*NPTS+p)*WIDTH +: WIDTH] = WIDTH'(1);
      return e;
   endfunction

   function automatic logic [EXP_W-1:0] out_vec();
      return {bus.w_err_out, bus.divisor_out, bus.dividend_out};
   endfunction

   task automatic drive_inputs(input h_arr_t h, input pt_arr_t xs, input pt_arr_t ys);
      for (int i = 0; i < 9; i++) bus.h_in[i] = COEF_W'(h[i]);
      for (int p = 0; p < NPTS; p++) begin
         bus.x_in[p] = WIDTH'(xs[p]);
         bus.y_in[p] = WIDTH'(ys[p]);
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle 1 with s = cycle 0.
   task automatic run_txn(input h_arr_t h, input pt_arr_t xs, input pt_arr_t ys, output int s);
      int budget;
      budget = 0;
      while ((bus.busy_out || bus.valid_out) && budget < 200) begin
         @(negedge clk_in);
         budget++;
      end
      if (budget >= 200) chk("idle_timeout", 1, 0);
      chk("hold_outputs", out_vec(), last_exp);
      drive_inputs(h, xs, ys);
      bus.start_in = 1'b1;
      s = cyc;
      exp_q.push_back(model(h, xs, ys));
      lat_q.push_back(s + LAT);
      @(negedge clk_in);
      bus.start_in = 1'b0;
      chk("busy_after_start", bus.busy_out, 1);
   endtask

   task automatic wait_all();
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 2*LAT + 10) begin
         @(negedge clk_in);
         budget++;
      end
      if (exp_q.size() > 0) begin
         chk("valid_timeout", exp_q.size(), 0);
         exp_q.delete();
         lat_q.delete();
      end
   endtask

   always @(negedge clk_in) begin
      if (rst_in && bus.valid_out) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            logic [EXP_W-1:0] e;
            int l;
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            last_exp = e;
            chk("latency", cyc, l);
            chk("dividend", bus.dividend_out, e[2*NPTS*WIDTH-1:0]);
            chk("divisor", bus.divisor_out, e[3*NPTS*WIDTH-1:2*NPTS*WIDTH]);
            chk("w_err", bus.w_err_out, e[EXP_W-1]);
            chk("busy_at_valid", bus.busy_out, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      h_arr_t  h, hb;
      pt_arr_t xs, ys, xb, yb;
      int s, s2, cnt0;

      bus.start_in = 1'b0;
      bus.h_in = '0;
      bus.x_in = '0;
      bus.y_in = '0;
      rst_exp  = reset_vec();
      last_exp = rst_exp;
      repeat (3) @(negedge clk_in);
      chk("reset_busy", bus.busy_out, 0);
      chk("reset_valid", bus.valid_out, 0);
      chk("reset_outputs", out_vec(), rst_exp);
      chk("reset_state", bus.state_dbg, homography_pkg::IDLE);
      rst_in = 1'b1;
      @(negedge clk_in);

      // Identity, including the 0 and 511 corners.
      h = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
      xs = '{100, 0, 511}; ys = '{50, 0, 511};
      run_txn(h, xs, ys, s);
      wait_all();
      chk("identity_dividend", bus.dividend_out, {9'd511, 9'd511, 9'd0, 9'd0, 9'd50, 9'd100});
      chk("identity_divisor", bus.divisor_out, {9'd1, 9'd1, 9'd1});

      // Translate/scale.
      h = '{256, 0, 2560, 0, 256, -1280, 0, 0, 512};
      xs = '{100, 100, 100}; ys = '{50, 50, 50};
      run_txn(h, xs, ys, s);
      wait_all();
      chk("translate_xyw", {bus.divisor_out[0], bus.dividend_out[1], bus.dividend_out[0]},
          {9'd2, 9'd45, 9'd110});

      // Clamp low and high on X, back to back.
      h = '{-256, 0, 0, 0, 256, 0, 0, 0, 256};
      xs = '{20, 20, 20}; ys = '{7, 300, 511};
      run_txn(h, xs, ys, s);
      h = '{1024, 0, 0, 0, 256, 0, 0, 0, 256};
      xs = '{200, 200, 200};
      run_txn(h, xs, ys, s);
      wait_all();
      chk("clamp_high_x", bus.dividend_out[0], 511);

      // Degenerate W, then a valid W clears the error flag.
      h = '{256, 0, 0, 0, 256, 0, 0, 0, 0};
      xs = '{10, 20, 30}; ys = '{40, 50, 60};
      run_txn(h, xs, ys, s);
      wait_all();
      chk("degenerate_err", bus.w_err_out, 1);
      h = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
      run_txn(h, xs, ys, s);
      wait_all();
      chk("err_cleared", bus.w_err_out, 0);

      // Starts at cycle 5 and in the valid cycle are ignored; inputs change after LOAD.
      hb = '{-500, 30, 900, 11, -256, 4000, 3, 3, 100};
      xb = '{1, 2, 3}; yb = '{4, 5, 6};
      cnt0 = done_cnt;
      h = '{300, 10, -700, -20, 280, 1500, 1, -1, 300};
      xs = '{123, 400, 17}; ys = '{222, 9, 480};
      run_txn(h, xs, ys, s);
      while (cyc < s + 5) @(negedge clk_in);
      drive_inputs(hb, xb, yb);
      bus.start_in = 1'b1;
      @(negedge clk_in);
      bus.start_in = 1'b0;
      while (cyc < s + LAT) @(negedge clk_in);
      chk("valid_at_38", bus.valid_out, 1);
      bus.start_in = 1'b1;
      @(negedge clk_in);
      bus.start_in = 1'b0;
      repeat (50) @(negedge clk_in);
      chk("single_valid", done_cnt - cnt0, 1);
      chk("idle_after_ignored", bus.busy_out, 0);

      // Reset mid-transaction at cycle 20 for two cycles.
      cnt0 = done_cnt;
      run_txn(h, xs, ys, s);
      while (cyc < s + 20) @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk("midreset_busy", bus.busy_out, 0);
      chk("midreset_outputs", out_vec(), rst_exp);
      exp_q.delete();
      lat_q.delete();
      last_exp = rst_exp;
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      repeat (LAT + 5) @(negedge clk_in);
      chk("midreset_no_valid", done_cnt - cnt0, 0);
      run_txn(h, xs, ys, s2);
      wait_all();

      // Randomized transactions, issued back to back.
      for (int t = 0; t < 12; t++) begin
         h[0] = int'($urandom_range(0, 512)) - 64;
         h[1] = int'($urandom_range(0, 256)) - 128;
         h[2] = int'($urandom_range(0, 40000)) - 20000;
         h[3] = int'($urandom_range(0, 256)) - 128;
         h[4] = int'($urandom_range(0, 512)) - 64;
         h[5] = int'($urandom_range(0, 40000)) - 20000;
         h[6] = int'($urandom_range(0, 16)) - 8;
         h[7] = int'($urandom_range(0, 16)) - 8;
         h[8] = int'($urandom_range(0, 9216)) - 1024;
         for (int p = 0; p < NPTS; p++) begin
            xs[p] = int'($urandom_range(0, 511));
            ys[p] = int'($urandom_range(0, 511));
         end
         run_txn(h, xs, ys, s);
      end
      wait_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
